// File: rtl/la_iopwrseq_pkg.sv
// Shared types and helpers for the IO ring power sequencer.
package la_iopwrseq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAMP   = 3'd1,
    SETTLE = 3'd2,
    UP     = 3'd3,
    DOWN   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  // Segment index width; a single-segment ring still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_dsync.sv
// Two-stage synchronizer bringing asynchronous pad signals into the clk domain.
module la_dsync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] data,
  output logic [W-1:0] sync
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= data;
      sync <= meta;
    end
  end

endmodule

// File: rtl/la_iopwrseq.sv
// Power sequencer for a segmented IO pad ring: ramps segments up one at a time,
// tears them down in reverse order and latches timeout / power-good-loss faults.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int NSEG = 4,
  parameter int CNTW = 8,
  parameter int TMO  = 200,
  parameter     SIDE = "NO"
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  en,
  input  logic [CNTW-1:0]       settle,
  input  logic [NSEG-1:0]       pgood,
  input  logic                  clrfault,
  output logic [NSEG-1:0]       ioen,
  output logic                  done,
  output logic                  fault,
  output logic [$clog2(NSEG):0] faultid
);

  localparam int IDXW = idx_width(NSEG);
  localparam int FIDW = $clog2(NSEG) + 1;
  localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TMO - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSEG - 1);
  localparam logic [FIDW-1:0] TMO_FLAG = FIDW'(1) << (FIDW - 1);
  localparam bit PARAM_OK = (NSEG >= 1) && (NSEG <= 16) && (TMO >= 1) &&
                            (TMO < (1 << CNTW)) &&
                            ((SIDE == "NO") || (SIDE == "SO") ||
                             (SIDE == "EA") || (SIDE == "WE"));

  if (!PARAM_OK) begin : g_bad_param
    $error("la_iopwrseq: illegal parameter combination");
  end

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt, idx_inc;
  logic [CNTW-1:0] cnt, cnt_nxt, settle_last;
  logic [NSEG-1:0] spg, lost, ioen_nxt;
  logic            done_nxt, fault_nxt;
  logic [FIDW-1:0] faultid_nxt, lost_id;

  la_dsync #(.W(NSEG)) u_pgood_sync (
    .clk    (clk),
    .nreset (nreset),
    .data   (pgood),
    .sync   (spg)
  );

  // A settle of 0 behaves like 1, so the terminal count saturates at 0.
  assign settle_last = (settle == '0) ? '0 : settle - CNTW'(1);
  assign idx_inc     = idx + IDXW'(1);
  assign lost        = ioen & ~spg;

  always_comb begin
    lost_id = '0;
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (lost[i]) lost_id = FIDW'(i);
    end
  end

  // Priority inside each state: fault, then en=0, then normal progress.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    ioen_nxt    = ioen;
    done_nxt    = done;
    fault_nxt   = fault;
    faultid_nxt = faultid;
    case (state)
      IDLE: begin
        if (en) begin
          idx_nxt   = '0;
          cnt_nxt   = '0;
          ioen_nxt  = NSEG'(1);
          state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (!spg[idx] && (cnt == TMO_LAST)) begin
          state_nxt   = FAULT;
          ioen_nxt    = '0;
          fault_nxt   = 1'b1;
          faultid_nxt = FIDW'(idx) | TMO_FLAG;
        end else if (!en) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (spg[idx]) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      SETTLE, UP: begin
        if (|lost) begin
          state_nxt   = FAULT;
          ioen_nxt    = '0;
          done_nxt    = 1'b0;
          fault_nxt   = 1'b1;
          faultid_nxt = lost_id;
        end else if (!en) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
          done_nxt  = 1'b0;
        end else if (state == SETTLE) begin
          if (cnt >= settle_last) begin
            cnt_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt = UP;
              done_nxt  = 1'b1;
            end else begin
              idx_nxt           = idx_inc;
              ioen_nxt[idx_inc] = 1'b1;
              state_nxt         = RAMP;
            end
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end
      end
      DOWN: begin
        if (ioen == '0) begin
          state_nxt = IDLE;
        end else begin
          if (cnt == '0) begin
            ioen_nxt[idx] = 1'b0;
            if (idx != '0) idx_nxt = idx - IDXW'(1);
          end
          cnt_nxt = (cnt >= settle_last) ? '0 : cnt + CNTW'(1);
        end
      end
      FAULT: begin
        ioen_nxt = '0;
        if (clrfault && !en) begin
          state_nxt   = IDLE;
          fault_nxt   = 1'b0;
          faultid_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ioen_nxt  = '0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      ioen    <= '0;
      done    <= 1'b0;
      fault   <= 1'b0;
      faultid <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      ioen    <= ioen_nxt;
      done    <= done_nxt;
      fault   <= fault_nxt;
      faultid <= faultid_nxt;
    end
  end

endmodule

// File: tb/tb_la_iopwrseq.sv
// Self-checking bench for la_iopwrseq: expected outputs come from a timeline
// model (segment rise/clear cycles computed arithmetically from settle and pgood delays).
module tb_la_iopwrseq;

  localparam int NSEG = 4;
  localparam int CNTW = 8;
  localparam int TMO  = 200;
  localparam int FIDW = $clog2(NSEG) + 1;

  logic            clk = 1'b0;
  logic            nreset;
  logic            en;
  logic [CNTW-1:0] settle;
  logic [NSEG-1:0] pgood;
  logic            clrfault;
  logic [NSEG-1:0] ioen;
  logic            done;
  logic            fault;
  logic [FIDW-1:0] faultid;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  la_iopwrseq #(.NSEG(NSEG), .CNTW(CNTW), .TMO(TMO), .SIDE("EA")) dut (
    .clk      (clk),
    .nreset   (nreset),
    .en       (en),
    .settle   (settle),
    .pgood    (pgood),
    .clrfault (clrfault),
    .ioen     (ioen),
    .done     (done),
    .fault    (fault),
    .faultid  (faultid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are then stable for sampling and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Power-up from IDLE. stuck>=0 holds that segment's pgood low (timeout);
  // abort_seg>=0 pulls nreset during that segment's settle window.
  task automatic runPowerUp(input int settle_val, input int fixed_d, input int stuck,
                            input int abort_seg);
    int m, t_done, t_fault, t_end, abort_at;
    int d [NSEG];
    int rise [NSEG];
    logic [NSEG-1:0] exp_ioen;
    logic faulted;
    settle = CNTW'(settle_val);
    m = (settle_val == 0) ? 1 : settle_val;
    foreach (d[i]) d[i] = (fixed_d > 0) ? fixed_d : int'($urandom_range(6, 1));
    rise[0] = 1;
    for (int i = 1; i < NSEG; i++) rise[i] = rise[i-1] + d[i-1] + 3 + m;
    t_done   = rise[NSEG-1] + d[NSEG-1] + 3 + m;
    t_fault  = (stuck >= 0) ? rise[stuck] + TMO : 0;
    abort_at = (abort_seg >= 0) ?
               rise[abort_seg] + d[abort_seg] + 3 + int'($urandom_range(m - 1, 0)) : -1;
    t_end    = (stuck >= 0) ? t_fault + 3 : t_done + 2;
    en = 1'b1;
    for (int k = 1; k <= t_end; k++) begin
      tick();
      faulted  = (stuck >= 0) && (k >= t_fault);
      exp_ioen = '0;
      for (int i = 0; i < NSEG; i++)
        if (k >= rise[i] && !faulted && (stuck < 0 || i <= stuck)) exp_ioen[i] = 1'b1;
      checkOutput("up_ioen", 32'(ioen), 32'(exp_ioen));
      checkOutput("up_done", 32'(done), 32'((stuck < 0) && (k >= t_done)));
      checkOutput("up_fault", 32'(fault), 32'(faulted));
      if (faulted) checkOutput("tmo_faultid", 32'(faultid), 32'((1 << (FIDW - 1)) | stuck));
      if (k == abort_at) begin
        #2 nreset = 1'b0;
        #1;
        checkOutput("rst_ioen", 32'(ioen), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_fault", 32'(fault), 32'(0));
        en    = 1'b0;
        pgood = '0;
        #1 nreset = 1'b1;
        return;
      end
      for (int i = 0; i < NSEG; i++)
        if ((stuck < 0 || i < stuck) && k == rise[i] + d[i]) pgood[i] = 1'b1;
    end
    if (stuck >= 0) pgood = '0;
  endtask

  // Power-down from UP; with reen, en returns high mid-teardown and a new ramp follows.
  task automatic runPowerDown(input int settle_val, input bit reen);
    int m, t_idle, r, t_end;
    logic [NSEG-1:0] exp_ioen;
    settle = CNTW'(settle_val);
    m      = (settle_val == 0) ? 1 : settle_val;
    t_idle = 3 + (NSEG - 1) * m;
    r      = reen ? int'($urandom_range(t_idle, 1)) : -1;
    t_end  = reen ? t_idle : t_idle + 2;
    en     = 1'b0;
    pgood  = '0;
    for (int k = 1; k <= t_end; k++) begin
      tick();
      exp_ioen = '0;
      for (int i = 0; i < NSEG; i++)
        if (k < 2 + (NSEG - 1 - i) * m) exp_ioen[i] = 1'b1;
      checkOutput("dn_ioen", 32'(ioen), 32'(exp_ioen));
      checkOutput("dn_done", 32'(done), 32'(0));
      checkOutput("dn_fault", 32'(fault), 32'(0));
      if (k == r) en = 1'b1;
    end
    if (reen) runPowerUp(int'($urandom_range(5, 0)), 0, -1, -1);
  endtask

  // From UP, drop pgood on a random set of segments for 1..3 cycles.
  task automatic runLoss(output int fid);
    logic [NSEG-1:0] mask, exp_ioen;
    int len;
    mask = NSEG'($urandom_range((1 << NSEG) - 1, 1));
    len  = int'($urandom_range(3, 1));
    fid  = 0;
    for (int i = NSEG - 1; i >= 0; i--) if (mask[i]) fid = i;
    pgood = pgood & ~mask;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_ioen = (k < 3) ? {NSEG{1'b1}} : {NSEG{1'b0}};
      checkOutput("loss_ioen", 32'(ioen), 32'(exp_ioen));
      checkOutput("loss_done", 32'(done), 32'(k < 3));
      checkOutput("loss_fault", 32'(fault), 32'(k >= 3));
      if (k >= 3) checkOutput("loss_faultid", 32'(faultid), 32'(fid));
      if (k == len) pgood = pgood | mask;
    end
    pgood = '0;
  endtask

  // From FAULT with en=1: clrfault must be ignored until en is low.
  task automatic runClear(input int exp_fid);
    clrfault = 1'b1;
    tick();
    clrfault = 1'b0;
    checkOutput("clr_en1_fault", 32'(fault), 32'(1));
    checkOutput("clr_en1_faultid", 32'(faultid), 32'(exp_fid));
    checkOutput("clr_en1_ioen", 32'(ioen), 32'(0));
    en = 1'b0;
    tick();
    checkOutput("fault_hold", 32'(fault), 32'(1));
    clrfault = 1'b1;
    tick();
    clrfault = 1'b0;
    checkOutput("clr_fault", 32'(fault), 32'(0));
    checkOutput("clr_faultid", 32'(faultid), 32'(0));
    checkOutput("clr_ioen", 32'(ioen), 32'(0));
    checkOutput("clr_done", 32'(done), 32'(0));
    tick();
    checkOutput("idle_ioen", 32'(ioen), 32'(0));
  endtask

  task automatic applyStimulus(input int iterations);
    int fid;
    for (int it = 0; it < iterations; it++) begin
      runPowerUp(int'($urandom_range(5, 0)), 0, -1, -1);
      case ($urandom_range(2, 0))
        0: runPowerDown(int'($urandom_range(5, 0)), 1'b0);
        1: begin
          runPowerDown(int'($urandom_range(5, 0)), 1'b1);
          runPowerDown(int'($urandom_range(5, 0)), 1'b0);
        end
        default: begin
          runLoss(fid);
          runClear(fid);
        end
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fid;
    nreset   = 1'b0;
    en       = 1'b0;
    clrfault = 1'b0;
    settle   = CNTW'(3);
    pgood    = '0;
    #3;
    checkOutput("reset_ioen", 32'(ioen), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_fault", 32'(fault), 32'(0));
    checkOutput("reset_faultid", 32'(faultid), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    tick();
    checkOutput("idle_ioen", 32'(ioen), 32'(0));

    runPowerUp(3, 5, -1, -1);
    runPowerDown(2, 1'b0);

    runPowerUp(3, 5, 2, -1);
    runClear((1 << (FIDW - 1)) | 2);

    runPowerUp(2, 0, -1, -1);
    runLoss(fid);
    runClear(fid);

    runPowerUp(0, 0, -1, -1);
    runPowerDown(0, 1'b0);

    runPowerUp(int'($urandom_range(5, 0)), 0, -1, 2);
    tick();
    checkOutput("post_rst_ioen", 32'(ioen), 32'(0));
    tick();
    checkOutput("post_rst_ioen", 32'(ioen), 32'(0));
    runPowerUp(0, 0, -1, -1);
    runPowerDown(1, 1'b0);

    applyStimulus(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/la_iopwrseq.md
# la_iopwrseq

Parametrised power-sequencing controller for a segmented IO pad ring. It enables NSEG supply segments (e.g. ground/supply pad groups per ring side) one at a time, waits for each segment's power-good, and settles before moving on. It powers down in reverse order and latches a fault on timeout or lost power-good. It sits in the always-on core domain next to the la_iovdd/la_iovss pad instances and drives their segment enables.

## Interface
- NSEG, 4, number of ring segments sequenced (1..16)
- CNTW, 8, width of settle/timeout counters
- TMO, 200, cycles allowed for pgood to rise after ioen asserts (< 2^CNTW)
- SIDE, "NO", ring side tag ("NO","SO","EA","WE"); informational only, no logic effect

- clk  input  1  sequencer clock
- nreset  input  1  asynchronous active-low reset
- en  input  1  1 = power up the ring, 0 = power down
- settle  input  CNTW  settle cycles after each pgood / between power-down steps; 0 is treated as 1
- pgood  input  NSEG  per-segment power-good, asynchronous to clk
- clrfault  input  1  single-cycle pulse to clear FAULT
- ioen  output  NSEG  per-segment enable to pad switches
- done  output  1  all segments up and settled
- fault  output  1  sequencing fault latched
- faultid  output  $clog2(NSEG)+1  index of faulting segment; MSB=1 means timeout, MSB=0 means pgood loss

## Operation
- pgood is passed through a 2-flop synchronizer, giving spg. All logic uses spg.
- States: IDLE, RAMP, SETTLE, UP, DOWN, FAULT. Segment index idx, counter cnt.
- IDLE: ioen=0. On en=1: idx←0, cnt←0, ioen[0]←1, go to RAMP.
- RAMP: cnt increments each cycle.
  - spg[idx]=1: cnt←0, go to SETTLE.
  - cnt reaches TMO-1 without spg[idx]: FAULT with faultid={1,idx}.
- SETTLE: cnt increments each cycle. When cnt reaches max(settle,1)-1:
  - If idx<NSEG-1: idx←idx+1, set ioen[idx+1], cnt←0, go to RAMP.
  - Else go to UP.
- UP: done=1.
- Loss of power-good: in SETTLE or UP, any enabled segment with spg=0 goes to FAULT with faultid={0,lowest such index}.
- en=0 in RAMP, SETTLE or UP: go to DOWN with cnt←0 and idx unchanged. done drops the same cycle.
- DOWN:
  - Clear ioen[idx] on entry and every settle interval.
  - Decrement idx after each clear.
  - When ioen is all zero, go to IDLE.
  - pgood is ignored in DOWN.
- en=1 during DOWN: DOWN completes to IDLE first. Re-ramp starts on the following cycle if en is still 1.
- FAULT:
  - All ioen cleared immediately (registered).
  - fault=1, faultid held.
  - Exit to IDLE only on clrfault=1 with en=0. clrfault with en=1 is ignored.
- Reset:
  - ioen=0, done=0, fault=0, faultid=0, state IDLE, cnt=0, idx=0, synchronizer flops 0.
  - Asserting nreset mid-sequence drops all ioen asynchronously.

## Timing
- All outputs are registered.
- en→ioen[0] latency: 1 cycle.
- pgood edge→spg: 2 cycles. spg→SETTLE entry: 1 cycle.
- Per-segment up time: (time for pgood to rise) + 3 + max(settle,1) cycles. The final settle completes with done=1 on the next cycle.
- Timeout fires exactly TMO cycles after the ioen[idx] rising edge if spg never rises. fault is visible the cycle after.
- Power-down: NSEG segments clear over (NSEG-1)·max(settle,1)+1 cycles, then IDLE the cycle after.
- Simultaneous events in the same cycle: fault detection beats en=0, and en=0 beats the settle-complete advance.

## Structure
- Package la_iopwrseq_pkg holds:
  - state enum (IDLE, RAMP, SETTLE, UP, DOWN, FAULT), 3-bit encoding
  - localparam IDXW = $clog2(NSEG) helper function
- Sub-module la_dsync (existing 2-stage synchronizer), instantiated NSEG wide for pgood.
- Counter and FSM stay in la_iopwrseq.

## Test plan
- NSEG=4, settle=3, pgood rises 5 cycles after each ioen → ioen goes 0001, 0011, 0111, 1111 in order; done=1 at the predicted cycle; fault=0.
- pgood[2] held low, TMO=200 → ioen[2] high for 200 cycles; then ioen=0, fault=1, faultid=3'b110.
- All up, then pgood[1] pulses low for 3 cycles → fault=1, faultid=3'b001, ioen=0 within 3 cycles of the pulse.
- All up, en→0 with settle=2 → ioen goes 0111, 0011, 0001, 0000 at 2-cycle spacing; done=0 one cycle after en falls.
- settle=0 → behaves as settle=1. nreset asserted while in SETTLE for idx=2 → ioen=0 immediately, and a clean re-sequence from segment 0 after release.
- In FAULT: clrfault with en=1 → remains in FAULT; clrfault with en=0 → IDLE, fault=0, faultid=0.
